difftest_csr_snapshot_fifo: RTL and testbench
=============================================

Name: difftest_csr_snapshot_fifo

Overview:
Parametrised successor to the single-shot CSR difftest hook. On every commit pulse it captures a full CSR snapshot (NUM_CSR words of XLEN bits) into a DEPTH-entry FIFO. It drains each snapshot as a serial word stream over a valid/ready interface to the difftest reader, so the core never stalls on the checker. Snapshots lost to overflow are counted and visible through a sequence-number gap.

Parameters:
XLEN, 64, width of one CSR word
NUM_CSR, 18, CSR words per snapshot (index 0 = privilege mode, then mstatus..medeleg in fixed order)
DEPTH, 4, snapshot entries buffered (power of two, >=2)
SEQ_W, 16, width of snapshot sequence number

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
commit_valid  input  1  one-cycle pulse: capture csr_flat this cycle
csr_flat  input  NUM_CSR*XLEN  word i at bits [i*XLEN +: XLEN]
flush  input  1  synchronous: discard all buffered snapshots
out_valid  output  1  stream word valid
out_ready  input  1  reader accepts word
out_data  output  XLEN  current CSR word
out_idx  output  $clog2(NUM_CSR)  index of current word
out_last  output  1  high on word NUM_CSR-1
out_seq  output  SEQ_W  sequence number of the snapshot being streamed
count  output  $clog2(DEPTH)+1  occupied entries
full  output  1  count==DEPTH
drop_cnt  output  SEQ_W  saturating count of dropped snapshots

Behaviour:
- Reset (async, rst_n low): wr_ptr=rd_ptr=0, count=0, word index=0, seq counter=0, drop_cnt=0. Outputs: out_valid=0, out_idx=0, out_last=0, out_seq=0, out_data=0 (data masked while empty), full=0.
- Capture: commit_valid is accepted when count<DEPTH, or when count==DEPTH and a pop completes in the same cycle. The accepted snapshot is written at wr_ptr together with the current seq counter; wr_ptr wraps modulo DEPTH.
- Drop: commit_valid while full with no same-cycle pop. The snapshot is discarded and drop_cnt increments, saturating at all-ones.
- Seq counter: increments (wrapping) on every commit_valid, whether accepted or dropped. The reader detects a loss as a gap in out_seq.
- Stream: out_valid = (count!=0). out_data/out_idx/out_seq/out_last come from the entry at rd_ptr and the word index. These outputs are combinational from registered state (zero-latency read).
- Handshake: a word transfers on out_valid & out_ready.
  - Word index advances 0..NUM_CSR-1.
  - Transfer with out_last=1 is a pop: word index returns to 0, rd_ptr advances modulo DEPTH, count decrements.
  - While out_valid=1 and out_ready=0, all stream outputs are held stable.
- Simultaneous capture and pop: count is unchanged and both pointers advance. If count==1 at that moment, the new entry streams starting the next cycle; there is no bubble beyond one cycle.
- Capture into an empty FIFO: the snapshot appears on out_valid the cycle after commit_valid (one-cycle latency).
- flush:
  - Clears wr_ptr, rd_ptr, count and word index next cycle; out_valid=0 next cycle.
  - Overrides a same-cycle commit_valid, which is counted as neither accepted nor dropped. The seq counter still increments.
  - An in-progress partial snapshot is abandoned.
  - drop_cnt and the seq counter are not cleared.
- Reset asserted mid-stream: immediate return to reset values, with no partial state retained.
- Latency from commit to the last word of a snapshot, with out_ready held high and the FIFO empty: NUM_CSR cycles after the capture cycle.

Test Plan:
- Reset, then one commit with word i = 0x1000+i, out_ready=1 -> out_valid rises the next cycle; 18 consecutive words 0x1000..0x1011 with out_idx 0..17; out_last only on idx 17; out_seq=0; count returns to 0.
- out_ready=0, then 5 commits (seq 0..4) -> count=4, full=1, drop_cnt=1. Drain all -> out_seq sequence is 0,1,2,3; a 6th commit then streams with out_seq=5.
- Full FIFO, commit on the same cycle as the idx-17 transfer of the head entry -> accepted, drop_cnt unchanged, count stays 4.
- Random out_ready toggling (50%) across 3 snapshots -> every word is delivered exactly once, in order, and held stable during stalls.
- Flush at idx 7 of the head entry, with count=3 -> out_valid=0 the next cycle, count=0. The next commit streams from idx 0 with seq incremented past the flushed ones.
- rst_n pulsed low mid-stream at idx 10 -> all outputs return to zero asynchronously. After release, the first commit streams with out_seq=0.

Source files
------------

// File: rtl/difftest_csr_snapshot_fifo.sv
// Buffers full CSR snapshots taken on each commit and streams them one word at a time to the difftest reader.
// Overflowed snapshots are counted in drop_cnt and show up to the reader as a gap in out_seq.
module difftest_csr_snapshot_fifo #(
  parameter int XLEN    = 64,
  parameter int NUM_CSR = 18,
  parameter int DEPTH   = 4,
  parameter int SEQ_W   = 16,
  localparam int IDX_W  = $clog2(NUM_CSR),
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    commit_valid,
  input  logic [NUM_CSR*XLEN-1:0] csr_flat,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic [SEQ_W-1:0]        out_seq,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic [SEQ_W-1:0]        drop_cnt
);

  logic [NUM_CSR*XLEN-1:0] data_mem [DEPTH];
  logic [SEQ_W-1:0]        seq_mem  [DEPTH];
  logic [XLEN-1:0]         head_words [NUM_CSR];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] drop_q, drop_d;

  logic transfer, is_last, pop, accept, drop;

  assign out_valid = (count_q != '0);
  assign is_last   = (idx_q == IDX_W'(NUM_CSR - 1));
  assign transfer  = out_valid & out_ready;
  assign pop       = transfer & is_last;
  // A full FIFO can still take a commit if the head is leaving on the same edge.
  assign accept    = commit_valid & ~flush & ((count_q != CNT_W'(DEPTH)) | pop);
  assign drop      = commit_valid & ~flush & ~accept;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    seq_d    = commit_valid ? seq_q + SEQ_W'(1) : seq_q;
    drop_d   = drop_q;
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + SEQ_W'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (transfer) begin
        idx_d = pop ? '0 : idx_q + IDX_W'(1);
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end

  // Storage carries no reset; the empty-masking on the outputs hides stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wr_ptr_q] <= csr_flat;
      seq_mem[wr_ptr_q]  <= seq_q;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CSR; gi++) begin : g_head_word
      assign head_words[gi] = data_mem[rd_ptr_q][gi*XLEN +: XLEN];
    end
  endgenerate

  assign out_data = out_valid ? head_words[idx_q] : '0;
  assign out_seq  = out_valid ? seq_mem[rd_ptr_q] : '0;
  assign out_idx  = idx_q;
  assign out_last = out_valid & is_last;
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_difftest_csr_snapshot_fifo.sv
// Scoreboard bench for the CSR snapshot FIFO: every accepted snapshot is queued word by word
// and checked against the stream as the reader accepts it.
module tb_difftest_csr_snapshot_fifo;
  localparam int XLEN = 64;
  localparam int NCSR = 18;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic commit_valid = 1'b0;
  logic [NCSR*XLEN-1:0] csr_flat = '0;
  logic flush = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [XLEN-1:0] out_data;
  logic [4:0] out_idx;
  logic out_last;
  logic [SEQ_W-1:0] out_seq;
  logic [2:0] count;
  logic full;
  logic [SEQ_W-1:0] drop_cnt;

  difftest_csr_snapshot_fifo #(.XLEN(XLEN), .NUM_CSR(NCSR), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .csr_flat(csr_flat), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_seq(out_seq), .count(count), .full(full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [4:0]       idx;
    logic [SEQ_W-1:0] seq;
  } word_t;

  word_t sb[$];
  int tests_run = 0;
  int fail_cnt = 0;
  logic [SEQ_W-1:0] exp_seq = '0;

  // Stream monitor: pops the scoreboard on each transfer and checks hold-stable during stalls.
  initial begin
    word_t e;
    bit stall_v;
    logic [XLEN+5+SEQ_W:0] stall_snap;
    stall_v = 1'b0;
    stall_snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v && out_valid) begin
          tests_run++;
          if ({out_data, out_idx, out_seq, out_last} !== stall_snap) begin
            fail_cnt++;
            $display("[TB] FAIL stall_hold: got %h want %h", {out_data, out_idx, out_seq, out_last}, stall_snap);
          end
        end
        if (out_valid && out_ready) begin
          tests_run++;
          if (sb.size() == 0) begin
            fail_cnt++;
            $display("[TB] FAIL unexpected_word: got seq=%0d idx=%0d data=%h, want no word", out_seq, out_idx, out_data);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.data || out_idx !== e.idx || out_seq !== e.seq || out_last !== (e.idx == 5'd17)) begin
              fail_cnt++;
              $display("[TB] FAIL stream_word: got seq=%0d idx=%0d last=%b data=%h, want seq=%0d idx=%0d last=%b data=%h",
                       out_seq, out_idx, out_last, out_data, e.seq, e.idx, (e.idx == 5'd17), e.data);
            end else begin
              $display("[TB] word seq=%0d idx=%0d data=%h", out_seq, out_idx, out_data);
            end
          end
        end
        stall_v = out_valid && !out_ready && !flush;
        stall_snap = {out_data, out_idx, out_seq, out_last};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    commit_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    exp_seq = '0;
  endtask

  task automatic commit_snap(input bit rnd, input logic [XLEN-1:0] base, input bit accepted);
    logic [XLEN-1:0] w;
    for (int i = 0; i < NCSR; i++) begin
      w = rnd ? {$urandom(), $urandom()} : base + 64'(i);
      csr_flat[i*XLEN +: XLEN] = w;
      if (accepted) sb.push_back('{w, 5'(i), exp_seq});
    end
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    exp_seq++;
  endtask

  task automatic drain(input int max_cyc);
    out_ready = 1'b1;
    for (int n = 0; n < max_cyc && sb.size() != 0; n++) step();
  endtask

  task automatic step_until_idx(input logic [4:0] target);
    for (int n = 0; n < 100 && out_idx !== target; n++) step();
    tests_run++;
    if (out_idx !== target) begin
      fail_cnt++;
      $display("[TB] FAIL reach_idx: got %0d want %0d", out_idx, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({out_valid, out_idx, out_last, out_seq, out_data, full, count, drop_cnt} !== '0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_outputs: valid=%b idx=%0d last=%b seq=%0d data=%h full=%b count=%0d drop=%0d, want all 0",
               out_valid, out_idx, out_last, out_seq, out_data, full, count, drop_cnt);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    int n;
    do_reset();
    out_ready = 1'b1;
    commit_snap(1'b0, 64'h1000, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL single_latency: out_valid=%b want 1", out_valid);
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (n != NCSR) begin
      fail_cnt++;
      $display("[TB] FAIL single_cycles: got %0d want %0d", n, NCSR);
    end
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL single_empty: count=%0d valid=%b want 0 0", count, out_valid);
    end
    $display("[TB] test_single done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) commit_snap(1'b0, 64'h2000 + 64'(k) * 64'h100, k < DEPTH);
    tests_run++;
    if (count !== 3'd4 || full !== 1'b1 || drop_cnt !== 16'd1) begin
      fail_cnt++;
      $display("[TB] FAIL overflow_state: count=%0d full=%b drop=%0d want 4 1 1", count, full, drop_cnt);
    end
    drain(400);
    commit_snap(1'b0, 64'h3000, 1'b1);
    drain(100);
    tests_run++;
    if (sb.size() != 0 || count !== 3'd0 || drop_cnt !== 16'd1) begin
      fail_cnt++;
      $display("[TB] FAIL overflow_drain: pending=%0d count=%0d drop=%0d want 0 0 1", sb.size(), count, drop_cnt);
    end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_full_pop_commit();
    do_reset();
    for (int k = 0; k < DEPTH; k++) commit_snap(1'b0, 64'h4000 + 64'(k) * 64'h100, 1'b1);
    out_ready = 1'b1;
    step_until_idx(5'd17);
    commit_snap(1'b0, 64'h5000, 1'b1);
    tests_run++;
    if (count !== 3'd4 || full !== 1'b1 || drop_cnt !== 16'd0) begin
      fail_cnt++;
      $display("[TB] FAIL full_pop_commit: count=%0d full=%b drop=%0d want 4 1 0", count, full, drop_cnt);
    end
    drain(400);
    tests_run++;
    if (sb.size() != 0 || count !== 3'd0) begin
      fail_cnt++;
      $display("[TB] FAIL full_pop_drain: pending=%0d count=%0d want 0 0", sb.size(), count);
    end
    $display("[TB] test_full_pop_commit done");
  endtask

  task automatic test_random_ready();
    do_reset();
    for (int cyc = 0; cyc < 800 && (sb.size() != 0 || cyc < 15); cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (cyc % 6 == 0 && cyc < 15) commit_snap(1'b1, 64'h0, 1'b1);
      else step();
    end
    out_ready = 1'b0;
    tests_run++;
    if (sb.size() != 0 || count !== 3'd0 || drop_cnt !== 16'd0) begin
      fail_cnt++;
      $display("[TB] FAIL random_ready: pending=%0d count=%0d drop=%0d want 0 0 0", sb.size(), count, drop_cnt);
    end
    $display("[TB] test_random_ready done");
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) commit_snap(1'b0, 64'h6000 + 64'(k) * 64'h100, 1'b1);
    out_ready = 1'b1;
    step_until_idx(5'd7);
    tests_run++;
    if (count !== 3'd3) begin
      fail_cnt++;
      $display("[TB] FAIL flush_pre_count: got %0d want 3", count);
    end
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
    tests_run++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      fail_cnt++;
      $display("[TB] FAIL flush_state: valid=%b count=%0d want 0 0", out_valid, count);
    end
    commit_snap(1'b0, 64'h7000, 1'b1);
    tests_run++;
    if (out_idx !== 5'd0 || out_seq !== 16'd3) begin
      fail_cnt++;
      $display("[TB] FAIL flush_restart: idx=%0d seq=%0d want 0 3", out_idx, out_seq);
    end
    drain(100);
    tests_run++;
    if (sb.size() != 0 || count !== 3'd0) begin
      fail_cnt++;
      $display("[TB] FAIL flush_drain: pending=%0d count=%0d want 0 0", sb.size(), count);
    end
    $display("[TB] test_flush done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    commit_snap(1'b0, 64'h8000, 1'b1);
    commit_snap(1'b0, 64'h8100, 1'b1);
    step_until_idx(5'd10);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_idx, out_last, out_seq, out_data, full, count, drop_cnt} !== '0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_mid: valid=%b idx=%0d last=%b seq=%0d data=%h count=%0d, want all 0",
               out_valid, out_idx, out_last, out_seq, out_data, count);
    end
    sb.delete();
    exp_seq = '0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    commit_snap(1'b0, 64'h9000, 1'b1);
    drain(100);
    tests_run++;
    if (sb.size() != 0 || count !== 3'd0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_mid_drain: pending=%0d count=%0d want 0 0", sb.size(), count);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop_commit();
    test_random_ready();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
